// File: rtl/util_upack2_timestamp.sv
// util_upack2_timestamp
// Timestamp gate between the TX DMA stream and the downstream unpacker.
// The DMA stream carries blocks of every_r sample beats, each preceded by a
// 64-bit timestamp word. A block is released when the free-running timestamp
// reaches its stamp. With timestamp_every == 0 the gate is a zero-latency
// pass-through.
// Optional feature macro: UTIL_UPACK2_TIMESTAMP_LATE_DROP_EN
//   defined   : late blocks are discarded and reset_upack is pulsed
//   undefined : late blocks are forwarded as if they were on time
module util_upack2_timestamp #(
    parameter int NUM_OF_CHANNELS     = 4,
    parameter int SAMPLE_DATA_WIDTH   = 16,
    parameter int SAMPLES_PER_CHANNEL = 1,
    localparam int DW = NUM_OF_CHANNELS * SAMPLE_DATA_WIDTH * SAMPLES_PER_CHANNEL
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic [63:0]   timestamp,
    input  logic [31:0]   timestamp_every,
    input  logic          s_axis_valid,
    output logic          s_axis_ready,
    input  logic          s_axis_xfer_req,
    input  logic [DW-1:0] s_axis_data,
    output logic          m_axis_valid,
    input  logic          m_axis_ready,
    output logic [DW-1:0] m_axis_data,
    output logic          reset_upack
);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_WAIT_TS = 3'd1;
    localparam logic [2:0] ST_HOLD    = 3'd2;
    localparam logic [2:0] ST_PASS    = 3'd3;
    localparam logic [2:0] ST_DROP    = 3'd4;

    logic [2:0]  state_r;
    logic [2:0]  state_nxt_s;
    logic        xfer_req_d_r;
    logic [31:0] every_r;
    logic [31:0] every_nxt_s;
    logic [63:0] ts_r;
    logic [63:0] ts_nxt_s;
    logic [31:0] cnt_r;
    logic [31:0] cnt_nxt_s;
    logic        reset_upack_r;
    logic        pulse_nxt_s;

    logic        xfer_rise_s;
    logic        cnt_last_s;
    logic        ready_s;
    logic        valid_s;
    logic [DW-1:0] data_s;

    assign xfer_rise_s = s_axis_xfer_req & ~xfer_req_d_r;
    assign cnt_last_s  = (cnt_r == (every_r - 32'd1));

    // Stream-side outputs: the data path is a direct wire in PASS, blocked elsewhere.
    always_comb begin
        ready_s = 1'b0;
        valid_s = 1'b0;
        data_s  = '0;
        case (state_r)
            ST_WAIT_TS: begin
                ready_s = 1'b1;
            end
            ST_PASS: begin
                ready_s = m_axis_ready;
                valid_s = s_axis_valid;
                if (s_axis_valid) begin
                    data_s = s_axis_data;
                end else begin
                    data_s = '0;
                end
            end
            ST_DROP: begin
                ready_s = 1'b1;
            end
            default: begin
                ready_s = 1'b0;
            end
        endcase
    end

    assign s_axis_ready = ready_s;
    assign m_axis_valid = valid_s;
    assign m_axis_data  = data_s;
    assign reset_upack  = reset_upack_r;

    // Next-state logic; a low xfer_req or a fresh rising edge overrides the block state.
    always_comb begin
        state_nxt_s = state_r;
        every_nxt_s = every_r;
        ts_nxt_s    = ts_r;
        cnt_nxt_s   = cnt_r;
        pulse_nxt_s = 1'b0;
        if (!s_axis_xfer_req) begin
            state_nxt_s = ST_IDLE;
            cnt_nxt_s   = 32'd0;
        end else if (xfer_rise_s) begin
            every_nxt_s = timestamp_every;
            pulse_nxt_s = 1'b1;
            cnt_nxt_s   = 32'd0;
            if (timestamp_every == 32'd0) begin
                state_nxt_s = ST_PASS;
            end else begin
                state_nxt_s = ST_WAIT_TS;
            end
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_nxt_s = ST_IDLE;
                end
                ST_WAIT_TS: begin
                    if (s_axis_valid) begin
                        ts_nxt_s    = s_axis_data[63:0];
                        state_nxt_s = ST_HOLD;
                    end else begin
                        state_nxt_s = ST_WAIT_TS;
                    end
                end
                ST_HOLD: begin
                    if (ts_r == timestamp) begin
                        state_nxt_s = ST_PASS;
                        cnt_nxt_s   = 32'd0;
                    end else if (ts_r > timestamp) begin
                        state_nxt_s = ST_HOLD;
                    end else begin
                        // Stamp already in the past; no wrap-around handling.
                        cnt_nxt_s = 32'd0;
`ifdef UTIL_UPACK2_TIMESTAMP_LATE_DROP_EN
                        state_nxt_s = ST_DROP;
                        pulse_nxt_s = 1'b1;
`else
                        state_nxt_s = ST_PASS;
`endif
                    end
                end
                ST_PASS: begin
                    if (s_axis_valid && m_axis_ready) begin
                        if ((every_r != 32'd0) && cnt_last_s) begin
                            state_nxt_s = ST_WAIT_TS;
                            cnt_nxt_s   = 32'd0;
                        end else begin
                            cnt_nxt_s = cnt_r + 32'd1;
                        end
                    end else begin
                        cnt_nxt_s = cnt_r;
                    end
                end
                ST_DROP: begin
                    if (s_axis_valid) begin
                        if (cnt_last_s) begin
                            state_nxt_s = ST_WAIT_TS;
                            cnt_nxt_s   = 32'd0;
                        end else begin
                            cnt_nxt_s = cnt_r + 32'd1;
                        end
                    end else begin
                        cnt_nxt_s = cnt_r;
                    end
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                    cnt_nxt_s   = 32'd0;
                end
            endcase
        end
    end

    // State, block bookkeeping and the registered upack flush pulse.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r       <= ST_IDLE;
            xfer_req_d_r  <= 1'b0;
            every_r       <= 32'd0;
            ts_r          <= 64'd0;
            cnt_r         <= 32'd0;
            reset_upack_r <= 1'b0;
        end else begin
            state_r       <= state_nxt_s;
            xfer_req_d_r  <= s_axis_xfer_req;
            every_r       <= every_nxt_s;
            ts_r          <= ts_nxt_s;
            cnt_r         <= cnt_nxt_s;
            reset_upack_r <= pulse_nxt_s;
        end
    end

endmodule

// File: tb/tb_util_upack2_timestamp.sv
// Self-checking bench for util_upack2_timestamp: a table of directed
// scenarios, randomized scenarios scored against a stream-level model, and
// hand-written abort sequences (xfer_req drop, asynchronous reset).
module tb_util_upack2_timestamp;

    localparam int DW = 64;

    logic          clk = 1'b0;
    logic          resetn;
    logic [63:0]   timestamp = 64'h0000_0000_0000_1000;
    logic [31:0]   timestamp_every;
    logic          s_axis_valid;
    logic          s_axis_ready;
    logic          s_axis_xfer_req;
    logic [DW-1:0] s_axis_data;
    logic          m_axis_valid;
    logic          m_axis_ready;
    logic [DW-1:0] m_axis_data;
    logic          reset_upack;

    int checks   = 0;
    int failures = 0;
    int cycle    = 0;

    util_upack2_timestamp dut (
        .clk             (clk),
        .resetn          (resetn),
        .timestamp       (timestamp),
        .timestamp_every (timestamp_every),
        .s_axis_valid    (s_axis_valid),
        .s_axis_ready    (s_axis_ready),
        .s_axis_xfer_req (s_axis_xfer_req),
        .s_axis_data     (s_axis_data),
        .m_axis_valid    (m_axis_valid),
        .m_axis_ready    (m_axis_ready),
        .m_axis_data     (m_axis_data),
        .reset_upack     (reset_upack)
    );

    // Clock
    always #5 clk = ~clk;

    // Free-running sample time and cycle index
    always @(posedge clk) begin
        cycle     <= cycle + 1;
        timestamp <= timestamp + 64'd1;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] make_beat(input int k);
        logic [15:0] a, b, c, d;
        a = 16'(4 * k + 1);
        b = 16'(4 * k + 2);
        c = 16'(4 * k + 3);
        d = 16'(4 * k + 4);
        return {d, c, b, a};
    endfunction

    // Stream monitor
    bit          mon_en = 1'b0;
    logic [63:0] out_q[$];
    int          out_cyc_q[$];
    int          pulse_cnt, viol_zero, viol_mirror, viol_data;

    initial begin
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (reset_upack === 1'b1) pulse_cnt++;
                if (m_axis_valid === 1'b1) begin
                    if (s_axis_ready !== m_axis_ready) viol_mirror++;
                    if (m_axis_data !== s_axis_data) viol_data++;
                    if (m_axis_ready === 1'b1) begin
                        out_q.push_back(m_axis_data);
                        out_cyc_q.push_back(cycle);
                    end
                end else if (m_axis_data !== 64'd0) begin
                    viol_zero++;
                end
            end
        end
    end

    // One transfer: build the DMA stream, drive it, and score the forwarded beats.
    task automatic run_scenario(input string name, input int every, input int offset,
                                input int nunits, input int vpct, input int rpct,
                                input bit rand_data, input bit use_exp,
                                input int exp_beats, input int exp_pulses);
        logic [63:0] in_q[$];
        bit          is_ts_q[$];
        logic [63:0] exp_q[$];
        int          exp_cyc_q[$];
        int          model_pulses = 1;
        int          idx = 0;
        int          guard = 0;
        int          beat_k = 0;
        bit          full_rate;
        bit          late, drop;
        longint      hold;
        logic [63:0] beat;

        full_rate = (vpct == 100) && (rpct == 100);
        for (int u = 0; u < nunits; u++) begin
            if (every != 0) begin
                in_q.push_back(64'd0);
                is_ts_q.push_back(1'b1);
            end
            for (int j = 0; j < ((every == 0) ? 1 : every); j++) begin
                if (rand_data) beat = {$urandom, $urandom};
                else           beat = make_beat(beat_k);
                beat_k++;
                in_q.push_back(beat);
                is_ts_q.push_back(1'b0);
            end
        end

        out_q.delete();
        out_cyc_q.delete();
        pulse_cnt = 0; viol_zero = 0; viol_mirror = 0; viol_data = 0;
        mon_en = 1'b1;

        @(posedge clk); #1;
        timestamp_every = 32'(every);
        s_axis_xfer_req = 1'b1;
        while (idx < in_q.size() && guard < 3000) begin
            s_axis_valid = (int'($urandom_range(99)) < vpct);
            m_axis_ready = (int'($urandom_range(99)) < rpct);
            if (is_ts_q[idx]) s_axis_data = timestamp + 64'(offset);
            else              s_axis_data = in_q[idx];
            @(negedge clk);
            if (s_axis_valid && s_axis_ready) begin
                if (is_ts_q[idx]) begin
                    // First HOLD cycle sees timestamp+1; anything not beyond the
                    // accept-time value is late.
                    late = (s_axis_data <= timestamp);
`ifdef UTIL_UPACK2_TIMESTAMP_LATE_DROP_EN
                    drop = late;
`else
                    drop = 1'b0;
`endif
                    if (drop) model_pulses++;
                    hold = late ? 64'sd1 : longint'(s_axis_data - timestamp);
                    for (int j = 0; j < every; j++) begin
                        if (!drop) begin
                            exp_q.push_back(in_q[idx + 1 + j]);
                            exp_cyc_q.push_back((j == 0 && full_rate) ? (cycle + 1 + int'(hold)) : -1);
                        end
                    end
                end else if (every == 0) begin
                    exp_q.push_back(in_q[idx]);
                    exp_cyc_q.push_back(-1);
                end
                idx++;
            end
            @(posedge clk); #1;
            guard++;
        end
        check({name, "_stream_done"}, 64'(idx), 64'(in_q.size()));
        s_axis_valid = 1'b0;
        m_axis_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 s_axis_xfer_req = 1'b0;
        repeat (2) @(posedge clk);
        #1 mon_en = 1'b0;

        check({name, "_beat_count"}, 64'(out_q.size()), 64'(exp_q.size()));
        check({name, "_pulses"}, 64'(pulse_cnt), 64'(model_pulses));
        if (use_exp) begin
            check({name, "_tbl_beats"}, 64'(out_q.size()), 64'(exp_beats));
            check({name, "_tbl_pulses"}, 64'(pulse_cnt), 64'(exp_pulses));
        end
        for (int i = 0; i < exp_q.size() && i < out_q.size(); i++) begin
            check({name, "_data"}, out_q[i], exp_q[i]);
            if (exp_cyc_q[i] >= 0)
                check({name, "_release_cycle"}, 64'(out_cyc_q[i]), 64'(exp_cyc_q[i]));
        end
        check({name, "_idle_data_zero"}, 64'(viol_zero), 64'd0);
        check({name, "_ready_mirror"}, 64'(viol_mirror), 64'd0);
        check({name, "_passthru_data"}, 64'(viol_data), 64'd0);
    endtask

    // xfer_req drops mid-block, then a fresh transfer starts.
    task automatic abort_xfer_seq();
        int  seen = 0;
        int  g = 0;
        bit  stamp_phase = 1'b1;
        @(posedge clk); #1;
        timestamp_every = 32'd4;
        s_axis_xfer_req = 1'b1;
        m_axis_ready    = 1'b1;
        s_axis_valid    = 1'b1;
        while (seen < 2 && g < 50) begin
            if (stamp_phase) s_axis_data = timestamp + 64'd1;
            else             s_axis_data = make_beat(100 + g);
            @(negedge clk);
            if (s_axis_ready && stamp_phase) stamp_phase = 1'b0;
            if (m_axis_valid && m_axis_ready) seen++;
            @(posedge clk); #1;
            g++;
        end
        check("abort_progress", 64'(seen), 64'd2);
        s_axis_xfer_req = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("abort_s_ready", 64'(s_axis_ready), 64'd0);
        check("abort_m_valid", 64'(m_axis_valid), 64'd0);
        check("abort_m_data", m_axis_data, 64'd0);
        check("abort_no_pulse", 64'(reset_upack), 64'd0);
        @(posedge clk); #1;
        s_axis_valid    = 1'b0;
        s_axis_xfer_req = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("restart_pulse", 64'(reset_upack), 64'd1);
        check("restart_wait_ts", 64'(s_axis_ready), 64'd1);
        @(negedge clk);
        check("restart_pulse_end", 64'(reset_upack), 64'd0);
        #1 s_axis_xfer_req = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    // Asynchronous reset mid-block, then a fresh transfer.
    task automatic abort_reset_seq();
        @(posedge clk); #1;
        timestamp_every = 32'd0;
        s_axis_xfer_req = 1'b1;
        s_axis_valid    = 1'b1;
        m_axis_ready    = 1'b1;
        s_axis_data     = make_beat(200);
        repeat (3) @(posedge clk);
        #2;
        check("rst_mid_block_active", 64'(m_axis_valid), 64'd1);
        resetn = 1'b0;
        #1;
        check("rst_s_ready", 64'(s_axis_ready), 64'd0);
        check("rst_m_valid", 64'(m_axis_valid), 64'd0);
        check("rst_m_data", m_axis_data, 64'd0);
        check("rst_reset_upack", 64'(reset_upack), 64'd0);
        @(posedge clk); #1;
        s_axis_xfer_req = 1'b0;
        s_axis_valid    = 1'b0;
        @(posedge clk); #1;
        resetn = 1'b1;
        @(posedge clk); #1;
        timestamp_every = 32'd4;
        s_axis_xfer_req = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("rst_restart_pulse", 64'(reset_upack), 64'd1);
        check("rst_restart_wait_ts", 64'(s_axis_ready), 64'd1);
        #1 s_axis_xfer_req = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    typedef struct {
        string name;
        int    every;
        int    offset;
        int    nunits;
        int    vpct;
        int    rpct;
        int    exp_beats;
        int    exp_pulses;
    } vec_t;

    vec_t vecs[5];

    initial begin
        vecs[0] = '{"disabled",     0, 0, 12, 100, 100, 12, 1};
`ifdef UTIL_UPACK2_TIMESTAMP_LATE_DROP_EN
        vecs[1] = '{"late",         4, 0, 3,  100, 100, 0,  4};
`else
        vecs[1] = '{"late",         4, 0, 3,  100, 100, 12, 1};
`endif
        vecs[2] = '{"on_time",      4, 1, 3,  100, 100, 12, 1};
        vecs[3] = '{"early",        4, 2, 3,  100, 100, 12, 1};
        vecs[4] = '{"backpressure", 4, 1, 3,  100, 50,  12, 1};

        resetn          = 1'b0;
        timestamp_every = 32'd0;
        s_axis_valid    = 1'b0;
        s_axis_xfer_req = 1'b0;
        s_axis_data     = 64'd0;
        m_axis_ready    = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_s_ready", 64'(s_axis_ready), 64'd0);
        check("reset_m_valid", 64'(m_axis_valid), 64'd0);
        check("reset_m_data", m_axis_data, 64'd0);
        check("reset_reset_upack", 64'(reset_upack), 64'd0);
        @(posedge clk); #1;
        resetn = 1'b1;
        repeat (2) @(posedge clk);

        for (int v = 0; v < 5; v++) begin
            run_scenario(vecs[v].name, vecs[v].every, vecs[v].offset, vecs[v].nunits,
                         vecs[v].vpct, vecs[v].rpct, 1'b0, 1'b1,
                         vecs[v].exp_beats, vecs[v].exp_pulses);
        end

        abort_xfer_seq();
        abort_reset_seq();

        for (int r = 0; r < 10; r++) begin
            int ev, off, nu, vp, rp;
            ev  = int'($urandom_range(5));
            off = int'($urandom_range(4));
            nu  = (ev == 0) ? int'($urandom_range(10, 1)) : int'($urandom_range(3, 1));
            vp  = ($urandom_range(1) == 0) ? 100 : 60;
            rp  = ($urandom_range(1) == 0) ? 100 : 60;
            run_scenario("random", ev, off, nu, vp, rp, 1'b1, 1'b0, 0, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
